prod_accum: RTL and testbench

PROD_ACCUM -- requirements
Module: prod_accum

---
 rtl/prod_accum_pkg.sv | 19 +
 rtl/prod_accum_sat_add.sv | 25 ++
 rtl/prod_accum.sv | 122 ++++++++++++
 tb/tb_prod_accum.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/prod_accum_pkg.sv
// Shared types and constants for the product accumulator.
package prod_accum_pkg;

  // Frame FSM: collecting products, or holding a finished result.
  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  // Default accumulator/result width.
  localparam int DEF_ACC_W = 24;

  // Width of one unsigned 8x8 product.
  localparam int PROD_W = 16;

  // Count register width; holds up to 255 products per frame.
  localparam int CNT_W = 8;

endpackage : prod_accum_pkg

// File: rtl/prod_accum_sat_add.sv
// ACC_W-bit unsigned saturating add of a zero-extended product.
// i_ovf-style flag is raised whenever the unclamped sum needs bit ACC_W.
module sat_add
  import prod_accum_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]  i_a,
  input  logic [PROD_W-1:0] i_b,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_ovf
);

  logic [ACC_W:0] w_full;

  // Widen both operands by one bit so the carry out is visible, then clamp.
  // NOTE: every signal assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to remember the old value.
  always_comb begin
    w_full = {1'b0, i_a} + {{(ACC_W + 1 - PROD_W){1'b0}}, i_b};
    o_ovf  = w_full[ACC_W];
    o_sum  = w_full[ACC_W] ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
  end

endmodule : sat_add

// File: rtl/prod_accum.sv
// Frame accumulator: sums a stream of 16-bit products with saturation,
// then presents sum/count/overflow on a valid/ready output until taken.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int ACC_W   = DEF_ACC_W,
  parameter int MAX_LEN = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

  state_e             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_count;
  logic               r_ovf;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [ACC_W-1:0]   r_out_sum;
  logic [CNT_W-1:0]   r_out_count;
  logic               r_out_ovf;

  logic [ACC_W-1:0]   w_sum;
  logic               w_add_ovf;
  logic [CNT_W-1:0]   w_count_nxt;
  logic               w_accept;
  logic               w_frame_end;

  sat_add #(
    .ACC_W (ACC_W)
  ) u_sat_add (
    .i_a   (r_acc),
    .i_b   (in_prod),
    .o_sum (w_sum),
    .o_ovf (w_add_ovf)
  );

  // Acceptance and frame-termination decode for the current cycle.
  always_comb begin
    w_count_nxt = r_count + CNT_W'(1);
    w_accept    = in_valid && r_in_ready;
    w_frame_end = in_last || (w_count_nxt == MAX_CNT);
  end

  // Frame FSM with all outputs registered; clr outranks everything but reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ACCUM;
      r_acc       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else if (clr) begin
      r_state     <= ST_ACCUM;
      r_acc       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        ST_ACCUM: begin
          if (w_accept) begin
            r_acc   <= w_sum;
            r_count <= w_count_nxt;
            r_ovf   <= r_ovf | w_add_ovf;
            if (w_frame_end) begin
              // Publish the result including this product.
              r_state     <= ST_HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_sum   <= w_sum;
              r_out_count <= w_count_nxt;
              r_out_ovf   <= r_ovf | w_add_ovf;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            // Handoff: start an empty frame; the next product waits a cycle.
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_ACCUM;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;

endmodule : prod_accum

// File: tb/tb_prod_accum.sv
// Directed bench: one default-parameter instance (index 0) and one
// ACC_W=17 / MAX_LEN=4 instance (index 1), each with its own inputs.
module tb_prod_accum;

  logic        clk;
  logic        rst_n;
  logic        clr       [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [15:0] in_prod   [2];
  logic        in_last   [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [7:0]  out_count [2];
  logic        out_ovf   [2];
  logic [23:0] out_sum0;
  logic [16:0] out_sum1;

  int n_cmp;
  int n_err;

  prod_accum u_def (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr[0]),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .in_prod   (in_prod[0]),
    .in_last   (in_last[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .out_sum   (out_sum0),
    .out_count (out_count[0]),
    .out_ovf   (out_ovf[0])
  );

  prod_accum #(
    .ACC_W   (17),
    .MAX_LEN (4)
  ) u_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr[1]),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .in_prod   (in_prod[1]),
    .in_last   (in_last[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .out_sum   (out_sum1),
    .out_count (out_count[1]),
    .out_ovf   (out_ovf[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one product for exactly one edge (caller knows in_ready is 1).
  task automatic send(input int sel, input logic [15:0] prod, input logic last);
    in_valid[sel] = 1'b1;
    in_prod[sel]  = prod;
    in_last[sel]  = last;
    tick();
    in_valid[sel] = 1'b0;
    in_last[sel]  = 1'b0;
  endtask

  function automatic logic [31:0] sum_of(input int sel);
    return (sel == 0) ? 32'(out_sum0) : 32'(out_sum1);
  endfunction

  task automatic check_result(input string tag, input int sel, input logic [31:0] sum,
                              input logic [31:0] cnt, input logic ovf);
    check({tag, "_valid"}, 32'(out_valid[sel]), 32'd1);
    check({tag, "_sum"},   sum_of(sel), sum);
    check({tag, "_count"}, 32'(out_count[sel]), cnt);
    check({tag, "_ovf"},   32'(out_ovf[sel]), 32'(ovf));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      clr[s]       = 1'b0;
      in_valid[s]  = 1'b0;
      in_prod[s]   = '0;
      in_last[s]   = 1'b0;
      out_ready[s] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;

    // Reset state, still in reset.
    check("rst_valid", 32'(out_valid[0]), 32'd0);
    check("rst_ready", 32'(in_ready[0]), 32'd1);
    check("rst_sum", sum_of(0), 32'd0);
    check("rst_count", 32'(out_count[0]), 32'd0);
    check("rst_ovf", 32'(out_ovf[0]), 32'd0);
    rst_n = 1'b1;

    // 100 + 200 + 300, consumer always ready: one-cycle result pulse.
    out_ready[0] = 1'b1;
    send(0, 16'd100, 1'b0);
    check("basic_mid_valid", 32'(out_valid[0]), 32'd0);
    send(0, 16'd200, 1'b0);
    send(0, 16'd300, 1'b1);
    check_result("basic", 0, 32'd600, 32'd3, 1'b0);
    check("basic_hold_ready", 32'(in_ready[0]), 32'd0);
    tick();
    check("basic_pulse_end", 32'(out_valid[0]), 32'd0);
    check("basic_ready_back", 32'(in_ready[0]), 32'd1);
    check("basic_sum_kept", sum_of(0), 32'd600);

    // Back-pressure: HOLD for 5 cycles with a product waiting.
    out_ready[0] = 1'b0;
    send(0, 16'd5, 1'b1);
    in_valid[0] = 1'b1;
    in_prod[0]  = 16'd77;
    in_last[0]  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_ready", 32'(in_ready[0]), 32'd0);
      check_result("bp", 0, 32'd5, 32'd1, 1'b0);
      tick();
    end
    in_valid[0]  = 1'b0;
    in_last[0]   = 1'b0;
    out_ready[0] = 1'b1;
    tick();
    check("bp_released", 32'(out_valid[0]), 32'd0);
    send(0, 16'd1, 1'b1);
    check_result("bp_next", 0, 32'd1, 32'd1, 1'b0);
    tick();

    // clr mid-frame drops the accumulated 7+9 and the product on the clr cycle.
    send(0, 16'd7, 1'b0);
    send(0, 16'd9, 1'b0);
    clr[0] = 1'b1;
    send(0, 16'd50, 1'b1);
    clr[0] = 1'b0;
    check("clr_no_result", 32'(out_valid[0]), 32'd0);
    send(0, 16'd5, 1'b1);
    check_result("clr", 0, 32'd5, 32'd1, 1'b0);
    tick();

    // Asynchronous reset mid-frame after two products.
    send(0, 16'd3, 1'b0);
    send(0, 16'd4, 1'b0);
    rst_n = 1'b0;
    #2;
    check("arst_valid", 32'(out_valid[0]), 32'd0);
    check("arst_sum", sum_of(0), 32'd0);
    check("arst_count", 32'(out_count[0]), 32'd0);
    tick();
    rst_n = 1'b1;
    check("arst_still_idle", 32'(out_valid[0]), 32'd0);
    send(0, 16'd2, 1'b1);
    check_result("arst_next", 0, 32'd2, 32'd1, 1'b0);
    tick();

    // Saturation at ACC_W=17: 65535+65535 = 131070, +10 clamps to 131071.
    out_ready[1] = 1'b1;
    send(1, 16'd65535, 1'b0);
    send(1, 16'd65535, 1'b0);
    send(1, 16'd10, 1'b1);
    check_result("sat", 1, 32'd131071, 32'd3, 1'b1);
    tick();
    // Overflow does not leak into the next frame.
    send(1, 16'd8, 1'b1);
    check_result("sat_next", 1, 32'd8, 32'd1, 1'b0);
    tick();

    // MAX_LEN=4 with no last: frame closes at count 4, fifth product waits.
    out_ready[1] = 1'b0;
    for (int i = 0; i < 4; i++) send(1, 16'd1, 1'b0);
    check_result("maxlen", 1, 32'd4, 32'd4, 1'b0);
    in_valid[1] = 1'b1;
    in_prod[1]  = 16'd1;
    for (int i = 0; i < 2; i++) begin
      check("maxlen_stall", 32'(in_ready[1]), 32'd0);
      tick();
    end
    out_ready[1] = 1'b1;
    tick();
    // Handoff edge: fifth product not taken yet.
    check("maxlen_handoff", 32'(out_valid[1]), 32'd0);
    check("maxlen_ready", 32'(in_ready[1]), 32'd1);
    tick();
    // Fifth product accepted now; three more complete the second frame.
    in_valid[1] = 1'b0;
    for (int i = 0; i < 2; i++) send(1, 16'd1, 1'b0);
    check("maxlen_open", 32'(out_valid[1]), 32'd0);
    send(1, 16'd1, 1'b0);
    check_result("maxlen2", 1, 32'd4, 32'd4, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_prod_accum
